// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-requester arbiter: round-robin on contention, or fixed priority to A.
// Purely combinational; the previous winner is held by the parent.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  // Pick one winner; bit 0 is A, bit 1 is B.
  always_comb begin
    // NOTE: assigning a default first means every path drives gnt, so no latch is inferred.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (fixed_prio || (last_grant == GNT_B)) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register-file write port: sweeps every register to zero after
// reset or on a soft clear, then shares the port between the core
// writeback (A) and the debug/loader port (B).
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W         = regfile_pkg::DATA_W,
  parameter int ADDR_W         = regfile_pkg::ADDR_W,
  parameter int NUM_REGS       = regfile_pkg::NUM_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit RR_EN          = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

  if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
    $error("regfile_wr_arbiter: NUM_REGS exceeds the address space");
  end

  arb_state_e        state;
  logic [CNT_W-1:0]  clr_cnt;
  grant_e            last_grant;
  logic              run_open;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // The port only accepts once RUN is settled, and a clear request blocks it.
  assign run_open = rst_n && (state == ST_RUN) && init_done && !clr_req;
  assign req      = {b_valid, a_valid} & {2{run_open}};

  rr_arb2 u_arb (
    .req        (req),
    .fixed_prio (!RR_EN),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign sel_addr = gnt[1] ? b_addr : a_addr;
  assign sel_data = gnt[1] ? b_data : a_data;

  // Clear-sweep / run FSM with registered write-port outputs and status.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt    <= '0;
      last_grant <= GNT_B;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          rf_we     <= 1'b1;
          rf_waddr  <= clr_cnt[ADDR_W-1:0];
          rf_wdata  <= '0;
          busy      <= 1'b1;
          init_done <= 1'b0;
          if (clr_cnt == LAST_CNT) begin
            clr_cnt <= '0;
            state   <= ST_RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          busy  <= 1'b0;
          rf_we <= 1'b0;
          if (clr_req) begin
            state     <= ST_CLEAR;
            busy      <= 1'b1;
            init_done <= 1'b0;
          end else begin
            init_done <= 1'b1;
            if (gnt != 2'b00) begin
              last_grant <= gnt[1] ? GNT_B : GNT_A;
              // x0 is hardwired zero: accept the request but issue no write.
              if (sel_addr != ADDR_W'(ZERO_REG)) begin
                rf_we    <= 1'b1;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
              end
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset sweep, single writes,
// round-robin vs fixed contention, x0 handling, soft clear, mid-sweep reset.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, rf_we, init_done, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        f_a_ready, f_b_ready, f_rf_we, f_init_done, f_busy;
  logic [4:0]  f_rf_waddr;
  logic [31:0] f_rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_done(init_done), .busy(busy)
  );

  regfile_wr_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .a_valid(a_valid), .a_ready(f_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(f_b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(f_rf_we), .rf_waddr(f_rf_waddr), .rf_wdata(f_rf_wdata),
    .init_done(f_init_done), .busy(f_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 sweep writes to addresses 0..31, then init_done with no write.
  task automatic expect_sweep(input string tag);
    for (int k = 0; k < 32; k++) begin
      check({tag, "_a_ready"}, 32'(a_ready), 32'd0);
      tick();
      check({tag, "_we"}, 32'(rf_we), 32'd1);
      check({tag, "_waddr"}, 32'(rf_waddr), 32'(k));
      check({tag, "_wdata"}, rf_wdata, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_init"}, 32'(init_done), 32'd0);
    end
    tick();
    check({tag, "_done_init"}, 32'(init_done), 32'd1);
    check({tag, "_done_we"}, 32'(rf_we), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0077;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'h0;

    // Reset values, readies forced low even with a_valid.
    tick(); tick();
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_init", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);

    // Sweep after reset release, A held valid throughout.
    rst_n = 1'b1;
    expect_sweep("boot");
    check("boot_a_ready_after", 32'(a_ready), 32'd1);
    a_valid = 1'b0;

    // Single A write.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    check("wa_a_ready", 32'(a_ready), 32'd1);
    check("wa_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    check("wa_we", 32'(rf_we), 32'd1);
    check("wa_waddr", 32'(rf_waddr), 32'd5);
    check("wa_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    check("wa_we_off", 32'(rf_we), 32'd0);
    check("wa_waddr_hold", 32'(rf_waddr), 32'd5);

    // Single B write, leaves last_grant = B.
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0099;
    #1;
    check("wb_b_ready", 32'(b_ready), 32'd1);
    check("wb_a_ready", 32'(a_ready), 32'd0);
    tick();
    b_valid = 1'b0;
    check("wb_waddr", 32'(rf_waddr), 32'd9);
    check("wb_wdata", rf_wdata, 32'h0000_0099);

    // Contention for 4 cycles: RR gives A,B,A,B; fixed gives A every time.
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("fp_a_ready", 32'(f_a_ready), 32'd1);
      check("fp_b_ready", 32'(f_b_ready), 32'd0);
      tick();
      check("rr_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("rr_wdata", rf_wdata, (i % 2 == 0) ? 32'h11 : 32'h22);
      check("fp_waddr", 32'(f_rf_waddr), 32'd1);
      check("fp_we", 32'(f_rf_we), 32'd1);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // Address 0: accepted, no write, last_grant moves to A.
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234;
    #1;
    check("x0_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("x0_we", 32'(rf_we), 32'd0);
    check("x0_waddr_hold", 32'(rf_waddr), 32'd2);
    a_addr = 5'd1; a_data = 32'h11; b_valid = 1'b1;
    #1;
    check("x0_next_b_ready", 32'(b_ready), 32'd1);
    check("x0_next_a_ready", 32'(a_ready), 32'd0);
    tick();
    check("x0_next_waddr", 32'(rf_waddr), 32'd2);
    check("x0_next_we", 32'(rf_we), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;

    // Soft clear with A valid in the same cycle.
    clr_req = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    #1;
    check("clr_a_ready", 32'(a_ready), 32'd0);
    tick();
    clr_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_we", 32'(rf_we), 32'd0);
    check("clr_init", 32'(init_done), 32'd0);
    expect_sweep("clr");
    check("clr_a_ready_after", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check("clr_aw_we", 32'(rf_we), 32'd1);
    check("clr_aw_waddr", 32'(rf_waddr), 32'd3);
    check("clr_aw_wdata", rf_wdata, 32'h33);

    // Reset at sweep step 10, then a full restart.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("mid_waddr9", 32'(rf_waddr), 32'd9);
    rst_n = 1'b0;
    tick();
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_init", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    expect_sweep("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 32x32-bit register file.
- Shares that port between two requesters using a valid/ready handshake: A (core writeback) and B (debug/program-loader port).
- After reset, and on a soft-clear request, it sequences a full clear sweep that writes zero to every register.
- Sits between the writeback/debug logic and the register file write inputs.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers swept during clear.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with A winning.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr_req  in  1  single-cycle pulse; request a full clear sweep.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write accepted this cycle.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write accepted this cycle.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- init_done  out  1  high while in RUN.
- busy  out  1  high during a clear sweep.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values (while rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, busy=0, last_grant=B (so A wins first contest), clr_cnt=0. a_ready/b_ready are forced 0.
- States: CLEAR, RUN.
- Leaving reset: the state is CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR state:
  - Each cycle registers rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, then increments clr_cnt.
  - After the write to address NUM_REGS-1, go to RUN; clr_cnt returns to 0.
  - The sweep takes exactly NUM_REGS cycles. busy=1 and a_ready=b_ready=0 throughout.
  - clr_req during CLEAR is ignored; the sweep is not restarted.
- RUN state:
  - init_done=1, busy=0.
  - Grant is combinational from the valid signals. Only one ready is ever high in a cycle; a ready is only asserted alongside its own valid.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid, RR_EN=1: grant the requester that is not last_grant.
  - Both valid, RR_EN=0: grant A.
  - last_grant updates on every grant, contested or not.
  - Accepted write: rf_we/rf_waddr/rf_wdata are registered from the granted requester and appear 1 cycle after the accept edge.
  - No accept: rf_we=0 next cycle; rf_waddr/rf_wdata hold their values.
- Address 0:
  - A write to address 0 is accepted (ready=1, and last_grant updates).
  - rf_we stays 0 for it, because x0 is hardwired zero. The CLEAR sweep is the only source of a write to address 0.
- clr_req in RUN:
  - Takes priority over any valid in the same cycle. Both readies are 0 that cycle; enter CLEAR next cycle.
  - A write accepted in the previous cycle still completes on rf_* before the sweep begins.
- rst_n low mid-sweep or mid-write: the next edge applies the reset values and any pending write is dropped. After release, restart from the first step above.
- Width rules:
  - clr_cnt is ADDR_W+1 bits wide so the terminal compare against NUM_REGS-1 does not wrap.
  - NUM_REGS must be no greater than 2**ADDR_W.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, ZERO_REG=0;
  - enum arb_state_e {ST_CLEAR, ST_RUN};
  - enum grant_e {GNT_A, GNT_B}.
- One sub-module is natural: rr_arb2, a 2-requester round-robin/fixed arbiter.
  - Inputs: req[1:0], fixed_prio, last_grant.
  - Outputs: gnt[1:0].
  - Combinational; last_grant is held by the parent.

Test Plan:
- Reset release, CLEAR_ON_RESET=1:
  - rf_we=1 for exactly 32 cycles with rf_waddr 0..31, rf_wdata=0.
  - init_done rises on cycle 33; a_ready=0 throughout even with a_valid=1.
- RUN, a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle:
  - a_ready=1 that cycle.
  - The next cycle shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after shows rf_we=0.
- RR_EN=1, both valid continuously for 4 cycles (A addr 1, B addr 2):
  - Grants go A,B,A,B and rf_waddr goes 1,2,1,2.
  - With RR_EN=0 the same stimulus gives 1,1,1,1 and b_ready is never 1.
- a_valid=1, a_addr=0, a_data=0x1234:
  - a_ready=1, rf_we stays 0, no write issued.
  - Next contested cycle grants B (last_grant updated).
- clr_req=1 with a_valid=1 in the same cycle:
  - a_ready=0, busy=1 next cycle, 32-cycle zero sweep, then the A write is accepted after init_done returns to 1.
- rst_n=0 for 1 cycle at sweep step 10:
  - Outputs return to their reset values and the sweep restarts at address 0, completing 32 writes.
